// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state/class types, MIPS opcode fields and byte-lane helper
package mips_ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH = 3'd0, S_EXEC1 = 3'd1, S_EXEC2 = 3'd2, S_MDWAIT = 3'd3, S_HALT = 3'd4} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_MULDIV, C_MTHILO, C_LINK, C_NOP} iclass_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
    localparam logic [4:0] RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] lsb);
        return sz == SZ_BYTE ? 4'b0001 << lsb : sz == SZ_HALF ? (lsb[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/mips_instr_class.sv
// mips_instr_class: combinational decode of an instruction into class, access size and link flag
module mips_instr_class
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output iclass_t     o_class,
    output size_t       o_size,
    output logic        o_link
);
    logic [5:0] w_op, w_fn;
    logic [4:0] w_rt;
    logic       w_unused;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];
    assign w_rt = i_instr[20:16];
    assign w_unused = ^{i_instr[25:21], i_instr[15:6]};
    assign o_link = o_class == C_LINK;

    always_comb begin
        o_class = C_NOP;
        o_size = SZ_WORD;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: o_class = C_MULDIV;
                    FN_MTHI, FN_MTLO: o_class = C_MTHILO;
                    FN_JALR: o_class = C_LINK;
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MFHI, FN_MFLO,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: o_class = C_ALU;
                    default: o_class = C_NOP;
                endcase
            end
            OP_REGIMM: o_class = (w_rt == RT_BLTZAL || w_rt == RT_BGEZAL) ? C_LINK : C_NOP;
            OP_JAL: o_class = C_LINK;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: o_class = C_ALU;
            OP_LB, OP_LBU: begin
                o_class = C_LOAD;
                o_size = SZ_BYTE;
            end
            OP_LH, OP_LHU: begin
                o_class = C_LOAD;
                o_size = SZ_HALF;
            end
            OP_LW, OP_LWL, OP_LWR: o_class = C_LOAD;
            OP_SB: begin
                o_class = C_STORE;
                o_size = SZ_BYTE;
            end
            OP_SH: begin
                o_class = C_STORE;
                o_size = SZ_HALF;
            end
            OP_SW: o_class = C_STORE;
            default: o_class = C_NOP;
        endcase
    end
endmodule

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multicycle FETCH/EXEC sequencer with memory stalls, mul/div wait, HALT and stall counter
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int          MULDIV_CYCLES = 32,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] HALT_ADDR     = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc,
    input  logic             waitrequest,
    input  logic [1:0]       addr_lsb,
    output logic [2:0]       state,
    output logic             active,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       byte_en,
    output logic             ir_load,
    output logic             pc_en,
    output logic             reg_write,
    output logic             hilo_write,
    output logic             muldiv_start,
    output logic [CNT_W-1:0] stall_count
);
    localparam int MD_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    state_t          r_state, w_next;
    logic [MD_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] r_stall;
    iclass_t         w_class;
    size_t           w_size;
    logic            w_link, w_halt_pc, w_mem, w_md_done, w_stall;
    logic            w_f, w_e1, w_e2, w_mdl;

    mips_instr_class u_class (
        .i_instr(instruction),
        .o_class(w_class),
        .o_size (w_size),
        .o_link (w_link)
    );

    assign w_halt_pc = pc == HALT_ADDR;
    assign w_mem = w_class == C_LOAD || w_class == C_STORE;
    assign w_md_done = r_md_cnt == '0;
    assign w_stall = waitrequest && ((r_state == S_FETCH && !w_halt_pc) || (r_state == S_EXEC1 && w_mem));
    assign state = r_state;
    assign stall_count = r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_md_cnt <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC1 && w_class == C_MULDIV)
                r_md_cnt <= MD_W'(MULDIV_CYCLES - 1);
            else if (r_state == S_MDWAIT && !w_md_done)
                r_md_cnt <= r_md_cnt - 1'b1;
            if (w_stall && !(&r_stall))
                r_stall <= r_stall + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = w_halt_pc ? S_HALT : waitrequest ? S_FETCH : S_EXEC1;
            S_EXEC1:  w_next = w_class == C_MULDIV ? S_MDWAIT : !w_mem ? S_FETCH :
                               waitrequest ? S_EXEC1 : w_class == C_LOAD ? S_EXEC2 : S_FETCH;
            S_EXEC2:  w_next = S_FETCH;
            S_MDWAIT: w_next = w_md_done ? S_FETCH : S_MDWAIT;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Reset gates every strobe so an abandoned access never reaches memory.
    always_comb begin
        w_f = !reset && r_state == S_FETCH && !w_halt_pc;
        w_e1 = !reset && r_state == S_EXEC1;
        w_e2 = !reset && r_state == S_EXEC2;
        w_mdl = !reset && r_state == S_MDWAIT && w_md_done;
        mem_read = w_f || (w_e1 && w_class == C_LOAD);
        mem_write = w_e1 && w_class == C_STORE;
        ir_load = w_f && !waitrequest;
        muldiv_start = w_e1 && w_class == C_MULDIV;
        hilo_write = (w_e1 && w_class == C_MTHILO) || w_mdl;
        reg_write = (w_e1 && (w_class == C_ALU || w_link)) || w_e2;
        pc_en = (w_e1 && !w_mem && w_class != C_MULDIV) || (mem_write && !waitrequest) || w_e2 || w_mdl;
        byte_en = reset ? 4'b0000 : (r_state == S_EXEC1 && w_mem) ? lane_mask(w_size, addr_lsb) : 4'b1111;
        active = reset || r_state != S_HALT;
    end
endmodule
